// File: rtl/loop_seq_pkg.sv
// Shared definitions for the loop nest sequencer.
//   CNT_WIDTH_DEFAULT : default width of every loop index and bound
//   seq_state_e       : sequencer FSM state encoding
package loop_seq_pkg;

    localparam int CNT_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage : loop_seq_pkg

// File: rtl/loop_counter.sv
// One loop level of the nest: a wrapping up-counter with a latched bound.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear         : zero the count and latch 'bound' (start of a run)
//   enable        : advance one step; wraps to 0 after reaching the bound
//   bound         : inclusive last index, sampled only on clear
//   q             : current index
//   last          : q equals the latched bound (wrap happens on next enable)
module loop_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] bound,
    output logic [WIDTH-1:0] q,
    output logic             last
);

    logic [WIDTH-1:0] bound_q;

    // Wrap is decided by equality with the latched bound, so a bound of
    // all-ones never needs a carry-out bit.
    assign last = (q == bound_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q       <= '0;
            bound_q <= '0;
        end else if (clear) begin
            q       <= '0;
            bound_q <= bound;
        end else if (enable) begin
            q <= last ? '0 : q + WIDTH'(1);
        end
    end

endmodule : loop_counter

// File: rtl/loop_nest_sequencer.sv
// Three-deep loop nest index generator (m outermost, k innermost).
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : launch a run (honoured only in IDLE)
//   abort_i                : terminate any run, back to IDLE, no done pulse
//   bound_{m,n,k}_i        : inclusive last index per loop, latched at start
//   idx_valid_o            : index tuple valid (exactly while in RUN)
//   idx_ready_i            : consumer accepts the tuple
//   idx_{m,n,k}_o          : current indices
//   first_k_o / last_k_o   : k at 0 / k at its bound, while valid
//   busy_o                 : not IDLE
//   done_o                 : one-cycle pulse on normal completion
//   state_o                : current FSM state (debug visibility)
//
// Handshake: a tuple transfers on a cycle where idx_valid_o and idx_ready_i
// are both high; while valid is high and ready is low the tuple holds steady.
// valid never depends on ready, and abort_i cancels a same-cycle transfer.
module loop_nest_sequencer
    import loop_seq_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CNT_WIDTH-1:0] bound_m_i,
    input  logic [CNT_WIDTH-1:0] bound_n_i,
    input  logic [CNT_WIDTH-1:0] bound_k_i,
    output logic                 idx_valid_o,
    input  logic                 idx_ready_i,
    output logic [CNT_WIDTH-1:0] idx_m_o,
    output logic [CNT_WIDTH-1:0] idx_n_o,
    output logic [CNT_WIDTH-1:0] idx_k_o,
    output logic                 first_k_o,
    output logic                 last_k_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           state_o
);

    seq_state_e state;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;

    logic       launch;
    logic       handshake;
    logic       en_k;
    logic       en_n;
    logic       en_m;
    logic       last_k;
    logic       last_n;
    logic       last_m;
    logic       nest_done;

    assign launch    = (state == ST_IDLE) & start_i & ~abort_i;
    assign handshake = valid_q & idx_ready_i & ~abort_i;

    // Carry chain built from the inner counters' last flags.
    assign en_k      = handshake;
    assign en_n      = en_k & last_k;
    assign en_m      = en_n & last_n;
    assign nest_done = en_m & last_m;

    loop_counter #(.WIDTH(CNT_WIDTH)) u_cnt_k (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (launch),
        .enable (en_k),
        .bound  (bound_k_i),
        .q      (idx_k_o),
        .last   (last_k)
    );

    loop_counter #(.WIDTH(CNT_WIDTH)) u_cnt_n (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (launch),
        .enable (en_n),
        .bound  (bound_n_i),
        .q      (idx_n_o),
        .last   (last_n)
    );

    loop_counter #(.WIDTH(CNT_WIDTH)) u_cnt_m (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (launch),
        .enable (en_m),
        .bound  (bound_m_i),
        .q      (idx_m_o),
        .last   (last_m)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort_i) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state   <= ST_RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (nest_done) begin
                        state   <= ST_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign idx_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_o     = state;

    // Both flags come from registered count/bound state, never from ready.
    assign first_k_o   = valid_q & (idx_k_o == '0);
    assign last_k_o    = valid_q & last_k;

endmodule : loop_nest_sequencer

// File: tb/tb_loop_nest_sequencer.sv
module tb_loop_nest_sequencer;

    localparam int CW = 4;
    localparam int EW = 1 + 3 * CW + 2;

    localparam logic [1:0] ST_IDLE_V = 2'd0;

    logic          clk_i;
    logic          rst_ni;
    logic          start_i;
    logic          abort_i;
    logic [CW-1:0] bound_m_i;
    logic [CW-1:0] bound_n_i;
    logic [CW-1:0] bound_k_i;
    logic          idx_valid_o;
    logic          idx_ready_i;
    logic [CW-1:0] idx_m_o;
    logic [CW-1:0] idx_n_o;
    logic [CW-1:0] idx_k_o;
    logic          first_k_o;
    logic          last_k_o;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    state_o;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int valid_cycles = 0;
    bit rdy_toggle = 0;

    // Entry: {is_done, m, n, k, first_k, last_k}
    logic [EW-1:0] exp_q[$];

    loop_nest_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .bound_m_i   (bound_m_i),
        .bound_n_i   (bound_n_i),
        .bound_k_i   (bound_k_i),
        .idx_valid_o (idx_valid_o),
        .idx_ready_i (idx_ready_i),
        .idx_m_o     (idx_m_o),
        .idx_n_o     (idx_n_o),
        .idx_k_o     (idx_k_o),
        .first_k_o   (first_k_o),
        .last_k_o    (last_k_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ready driver: constant 1 or toggling every cycle
    initial begin
        idx_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (rdy_toggle) idx_ready_i = ~idx_ready_i;
            else            idx_ready_i = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] mk(input bit is_done, input int m, input int n,
                                         input int k, input bit f, input bit l);
        return {is_done, CW'(m), CW'(n), CW'(k), f, l};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_tuple(input int m, input int n, input int k, input int bk);
        exp_q.push_back(mk(1'b0, m, n, k, (k == 0), (k == bk)));
    endtask

    task automatic sb_compare(input string nm, input logic [EW-1:0] act, input bit pop);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h with empty expected queue", nm, act);
        end else begin
            e = exp_q[0];
            if (pop) void'(exp_q.pop_front());
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (idx_valid_o) valid_cycles++;
                if (idx_valid_o && !abort_i) begin
                    if (idx_ready_i) begin
                        hs_count++;
                        sb_compare("tuple", {1'b0, idx_m_o, idx_n_o, idx_k_o, first_k_o, last_k_o}, 1'b1);
                    end else begin
                        sb_compare("stall_hold", {1'b0, idx_m_o, idx_n_o, idx_k_o, first_k_o, last_k_o}, 1'b0);
                    end
                end
                if (done_o)
                    sb_compare("done", {1'b1, idx_m_o, idx_n_o, idx_k_o, first_k_o, last_k_o}, 1'b1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at #1 after a rising edge; returns at #1 after the edge that
    // brings the sequencer back to IDLE.
    task automatic run_nest(input int bm, input int bn, input int bk, input bit toggle);
        int  total;
        bit  seen;
        total = (bm + 1) * (bn + 1) * (bk + 1);
        for (int m = 0; m <= bm; m++)
            for (int n = 0; n <= bn; n++)
                for (int k = 0; k <= bk; k++)
                    push_tuple(m, n, k, bk);
        exp_q.push_back(mk(1'b1, 0, 0, 0, 1'b0, 1'b0));
        rdy_toggle   = toggle;
        hs_count     = 0;
        valid_cycles = 0;
        bound_m_i = CW'(bm);
        bound_n_i = CW'(bn);
        bound_k_i = CW'(bk);
        start_i   = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("start_accepted", int'(idx_valid_o), 1);
        // Bounds are latched; scrambling the inputs must not matter.
        bound_m_i = CW'($urandom_range(0, 15));
        bound_n_i = CW'($urandom_range(0, 15));
        bound_k_i = CW'($urandom_range(0, 15));
        seen = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        if (seen) begin
            check("handshakes", hs_count, total);
            if (!toggle) check("valid_cycles", valid_cycles, total);
            check("busy_in_done", int'({busy_o, idx_valid_o}), 2);
        end
        @(posedge clk_i);
        #1;
        check("idle_after_done", int'({busy_o, idx_valid_o, done_o}), 0);
        check("state_idle", int'(state_o), int'(ST_IDLE_V));
        rdy_toggle = 1'b0;
    endtask

    task automatic abort_scenario();
        push_tuple(0, 0, 0, 2);
        push_tuple(0, 0, 1, 2);
        push_tuple(0, 0, 2, 2);
        rdy_toggle = 1'b0;
        bound_m_i = 4'd1;
        bound_n_i = 4'd1;
        bound_k_i = 4'd2;
        start_i   = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("abort_at_idx", int'({idx_m_o, idx_n_o, idx_k_o}), int'({4'd0, 4'd1, 4'd0}));
        abort_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_valid_low", int'(idx_valid_o), 0);
        check("abort_no_done", int'({busy_o, done_o}), 0);
        check("abort_state", int'(state_o), int'(ST_IDLE_V));
        repeat (3) @(posedge clk_i);
        #1;
        check("abort_stays_idle", int'({idx_valid_o, busy_o, done_o}), 0);
    endtask

    task automatic reset_scenario();
        push_tuple(0, 0, 0, 1);
        push_tuple(0, 0, 1, 1);
        rdy_toggle = 1'b0;
        bound_m_i = 4'd1;
        bound_n_i = 4'd1;
        bound_k_i = 4'd1;
        start_i   = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        bound_m_i = 4'd0;
        bound_n_i = 4'd1;
        bound_k_i = 4'd0;
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_ctrl", int'({idx_valid_o, busy_o, done_o, first_k_o, last_k_o}), 0);
        check("async_rst_idx", int'({idx_m_o, idx_n_o, idx_k_o}), 0);
        check("async_rst_state", int'(state_o), int'(ST_IDLE_V));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst_idle", int'({idx_valid_o, busy_o}), 0);
        run_nest(0, 1, 0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_ni    = 1'b0;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        bound_m_i = '0;
        bound_n_i = '0;
        bound_k_i = '0;
        #12;
        check("reset_ctrl", int'({idx_valid_o, busy_o, done_o, first_k_o, last_k_o}), 0);
        check("reset_idx", int'({idx_m_o, idx_n_o, idx_k_o}), 0);
        check("reset_state", int'(state_o), int'(ST_IDLE_V));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        run_nest(1, 1, 2, 1'b0);   // 12 tuples, ready always high
        run_nest(1, 1, 2, 1'b1);   // same sequence with stalls
        run_nest(0, 0, 0, 1'b0);   // single tuple, first and last together
        run_nest(0, 0, 15, 1'b0);  // k at full width, no wrap into n
        run_nest(15, 0, 1, 1'b1);  // m at full width, stalls
        run_nest(1, 15, 0, 1'b0);  // n at full width
        abort_scenario();
        reset_scenario();

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_loop_nest_sequencer
